m_ifetch: RTL and testbench

M_IFETCH -- requirements
Module: m_ifetch

---
 rtl/m_ifetch.sv | 106 ++++++++++
 tb/tb_m_ifetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/m_ifetch.sv
// Instruction fetch stage: a word-addressed store feeding a registered fetch beat under valid/ready flow control.
// Optional macro IFETCH_BOUNDS_EN adds out-of-range detection on fetch and write addresses.
module m_ifetch #(
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 64,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_ready,
    input  logic              w_redirect,
    input  logic [31:0]       w_redirect_pc,
    input  logic              w_we,
    input  logic [31:0]       w_waddr,
    input  logic [DATA_W-1:0] w_wdata,
    output logic [DATA_W-1:0] r_inst,
    output logic [31:0]       r_pc,
    output logic              r_valid,
    output logic              r_err
);
    // Handshake: a beat is transferred on any edge where r_valid and w_ready are both 1;
    // the output register may refill whenever it is empty or being drained.
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [31:0]       f_pc_q, f_pc_d;
    logic [DATA_W-1:0] r_inst_q, r_inst_d;
    logic [31:0]       r_pc_q, r_pc_d;
    logic              r_valid_q, r_valid_d;
    logic              r_err_q, r_err_d;

    logic              adv;
    logic [AW-1:0]     rd_idx;
    logic [AW-1:0]     wr_idx;
    logic [DATA_W-1:0] fetch_inst;
    logic              fetch_err;
    logic              wr_ok;

    assign adv    = !r_valid_q || w_ready;
    assign rd_idx = f_pc_q[AW+1:2];
    assign wr_idx = w_waddr[AW+1:2];

`ifdef IFETCH_BOUNDS_EN
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

    always_comb begin
        fetch_err  = ({1'b0, f_pc_q} >= LIMIT);
        fetch_inst = fetch_err ? '0 : mem_q[rd_idx];
        wr_ok      = ({1'b0, w_waddr} < LIMIT);
    end
`else
    always_comb begin
        fetch_err  = 1'b0;
        fetch_inst = mem_q[rd_idx];
        wr_ok      = 1'b1;
    end
`endif

    // Redirect outranks both advance and stall; the pending beat is discarded.
    always_comb begin
        f_pc_d    = f_pc_q;
        r_inst_d  = r_inst_q;
        r_pc_d    = r_pc_q;
        r_valid_d = r_valid_q;
        r_err_d   = r_err_q;
        if (w_redirect) begin
            f_pc_d    = {w_redirect_pc[31:2], 2'b00};
            r_valid_d = 1'b0;
        end else if (adv) begin
            r_inst_d  = fetch_inst;
            r_pc_d    = f_pc_q;
            r_valid_d = 1'b1;
            r_err_d   = fetch_err;
            f_pc_d    = f_pc_q + 32'd4;
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            f_pc_q    <= RESET_PC;
            r_inst_q  <= '0;
            r_pc_q    <= '0;
            r_valid_q <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            f_pc_q    <= f_pc_d;
            r_inst_q  <= r_inst_d;
            r_pc_q    <= r_pc_d;
            r_valid_q <= r_valid_d;
            r_err_q   <= r_err_d;
        end
    end

    // Store is never reset; a same-edge read sees the old word.
    always_ff @(posedge w_clk) begin
        if (w_we && wr_ok) begin
            mem_q[wr_idx] <= w_wdata;
        end
    end

    assign r_inst  = r_inst_q;
    assign r_pc    = r_pc_q;
    assign r_valid = r_valid_q;
    assign r_err   = r_err_q;
endmodule

// File: tb/tb_m_ifetch.sv
// Bench for m_ifetch: directed scenarios then random traffic, checked against an address-arithmetic model.
module tb_m_ifetch;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              w_clk = 1'b0;
    logic              w_rst;
    logic              w_ready;
    logic              w_redirect;
    logic [31:0]       w_redirect_pc;
    logic              w_we;
    logic [31:0]       w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] r_inst;
    logic [31:0]       r_pc;
    logic              r_valid;
    logic              r_err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_mem [DEPTH];
    logic [31:0] m_fpc;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_err;

    m_ifetch #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .w_clk(w_clk), .w_rst(w_rst), .w_ready(w_ready),
        .w_redirect(w_redirect), .w_redirect_pc(w_redirect_pc),
        .w_we(w_we), .w_waddr(w_waddr), .w_wdata(w_wdata),
        .r_inst(r_inst), .r_pc(r_pc), .r_valid(r_valid), .r_err(r_err)
    );

    always #5 w_clk = ~w_clk;

    function automatic bit in_range(input logic [31:0] a);
`ifdef IFETCH_BOUNDS_EN
        return a < 32'(DEPTH * 4);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    // Model one clock edge from the current inputs.
    task automatic model_edge();
        logic [31:0] rd;
        rd = exp_mem[widx(m_fpc)];
        if (w_rst) begin
            m_fpc = RESET_PC; m_valid = 0; m_pc = 0; m_inst = 0; m_err = 0;
        end else if (w_redirect) begin
            m_fpc = w_redirect_pc & ~32'd3;
            m_valid = 0;
        end else if (!m_valid || w_ready) begin
            m_pc    = m_fpc;
            m_err   = !in_range(m_fpc);
            m_inst  = m_err ? 32'd0 : rd;
            m_valid = 1;
            m_fpc   = m_fpc + 32'd4;
        end
        if (w_we && in_range(w_waddr)) exp_mem[widx(w_waddr)] = w_wdata;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("model_valid", 32'(r_valid), 32'(m_valid));
        if (m_valid) begin
            chk("model_pc", r_pc, m_pc);
            chk("model_inst", r_inst, m_inst);
            chk("model_err", 32'(r_err), 32'(m_err));
        end
    endtask

    task automatic step();
        @(posedge w_clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        w_rst = 0; w_redirect = 0; w_redirect_pc = 0; w_we = 0; w_waddr = 0; w_wdata = 0;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        w_redirect = 1; w_redirect_pc = a;
        step();
        chk("redirect_valid", 32'(r_valid), 32'd0);
        w_redirect = 0;
    endtask

    initial begin
        logic [31:0] seed_words [4];
        seed_words[0] = 0; seed_words[1] = 1; seed_words[2] = 2; seed_words[3] = 4;
        m_fpc = 0; m_valid = 0; m_pc = 0; m_inst = 0; m_err = 0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 'x;
        idle_inputs();
        w_ready = 1;

        // Load the whole store while held in reset.
        w_rst = 1;
        for (int i = 0; i < DEPTH; i++) begin
            w_we    = 1;
            w_waddr = 32'(i * 4 + int'($urandom_range(0, 3)));
            w_wdata = (i < 4) ? seed_words[i] : $urandom;
            step();
        end
        w_we = 0;
        chk("rst_valid", 32'(r_valid), 32'd0);
        chk("rst_pc", r_pc, 32'd0);
        chk("rst_inst", r_inst, 32'd0);
        chk("rst_err", 32'(r_err), 32'd0);

        // Stream the first four words.
        w_rst = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_pc", r_pc, 32'(i * 4));
            chk("stream_inst", r_inst, seed_words[i]);
        end

        // Stall holding the beat at 0x4.
        w_rst = 1; step(); w_rst = 0;
        step(); step();
        chk("pre_stall_pc", r_pc, 32'h4);
        w_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", r_pc, 32'h4);
            chk("stall_inst", r_inst, 32'd1);
        end
        w_ready = 1;
        step();
        chk("post_stall_pc", r_pc, 32'h8);

        // Unaligned redirect, then back-to-back redirects.
        redirect_to(32'h0000_000E);
        step();
        chk("redir_pc", r_pc, 32'hC);
        chk("redir_inst", r_inst, 32'd4);
        w_redirect = 1; w_redirect_pc = 32'h20; step();
        chk("b2b_valid0", 32'(r_valid), 32'd0);
        redirect_to(32'h30);
        step();
        chk("b2b_pc", r_pc, 32'h30);

        // Same-cycle write of the word being read returns old data.
        redirect_to(32'h4);
        w_we = 1; w_waddr = 32'h4; w_wdata = 32'hDEAD;
        step();
        w_we = 0;
        chk("rbw_old", r_inst, 32'd1);
        redirect_to(32'h4);
        step();
        chk("rbw_new", r_inst, 32'hDEAD);

        // Fetch across the top of the store.
        redirect_to(32'hFC);
        step();
        chk("top_pc", r_pc, 32'hFC);
        step();
        chk("over_pc", r_pc, 32'h100);
`ifdef IFETCH_BOUNDS_EN
        chk("over_err", 32'(r_err), 32'd1);
        chk("over_inst", r_inst, 32'd0);
`else
        chk("over_err", 32'(r_err), 32'd0);
        chk("over_inst", r_inst, 32'd0);
`endif

        // Reset during a stall drops the held beat.
        w_ready = 0; step();
        chk("stall_hold_valid", 32'(r_valid), 32'd1);
        w_rst = 1; step();
        chk("rst_stall_valid", 32'(r_valid), 32'd0);
        w_rst = 0; w_ready = 1; step();
        chk("rst_first_pc", r_pc, RESET_PC);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            w_ready       = ($urandom_range(0, 9) < 7);
            w_redirect    = ($urandom_range(0, 9) == 0);
            w_redirect_pc = 32'($urandom_range(0, 511));
            w_we          = ($urandom_range(0, 4) == 0);
            w_waddr       = 32'($urandom_range(0, 511));
            w_wdata       = $urandom;
            w_rst         = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
